// File: rtl/pipe_ctrl.sv
// Pipeline controller: jump/stall merge, bus
// arbitration for an external master, stall watchdog.
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES  = 3,
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_jump_req_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        ex_hold_req_i,
  input  logic        int_req_i,
  input  logic [31:0] int_addr_i,
  output logic        int_ack_o,
  input  logic        bus_hold_req_i,
  output logic        bus_grant_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic [2:0]  hold_flag_o,
  output logic        timeout_o
);

  localparam int unsigned WD_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(STALL_TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic [WD_W-1:0] wd, wd_nxt;
  logic            taken;
  logic            ack;
  logic            stall;

  // State register, drain counter, grant, watchdog and trap-taken bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wd          <= '0;
      timeout_o   <= 1'b0;
      bus_grant_o <= 1'b0;
      taken       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      wd          <= wd_nxt;
      timeout_o   <= timeout_o | (wd_nxt == WD_LIM);
      bus_grant_o <= (state_nxt == GRANT);
      taken       <= int_req_i & (taken | ack);
    end
  end

  // Bus arbitration next-state and drain counting
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus_hold_req_i && !ex_hold_req_i) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        if (!bus_hold_req_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DRAIN_LAST) begin
          state_nxt = GRANT;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      GRANT: begin
        if (!bus_hold_req_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Prioritised jump/hold bundle; first matching row wins
  always_comb begin
    jump_flag_o = 1'b0;
    jump_addr_o = '0;
    hold_flag_o = 3'd0;
    ack         = 1'b0;
    if (rst) begin
      ack = 1'b0;
    end else if (state == GRANT) begin
      hold_flag_o = 3'd3;
    end else if (ex_jump_req_i) begin
      jump_flag_o = 1'b1;
      jump_addr_o = ex_jump_addr_i;
      hold_flag_o = 3'd3;
    end else if (ex_hold_req_i) begin
      hold_flag_o = 3'd3;
    end else if (state == IDLE && int_req_i && !taken) begin
      jump_flag_o = 1'b1;
      jump_addr_o = int_addr_i;
      hold_flag_o = 3'd3;
      ack         = 1'b1;
    end else if (state == DRAIN) begin
      hold_flag_o = 3'd1;
    end
  end

  assign int_ack_o = ack;
  assign stall = (hold_flag_o != 3'd0) && !jump_flag_o;

  // Watchdog: saturating stall count, frozen while the bus is granted
  always_comb begin
    wd_nxt = '0;
    if (state == GRANT) begin
      wd_nxt = wd;
    end else if (stall) begin
      wd_nxt = (wd == WD_MAX) ? wd : wd + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed
// vectors, expectations checked at negedge.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_jump_req_i = 1'b0;
  logic [31:0] ex_jump_addr_i = '0;
  logic        ex_hold_req_i = 1'b0;
  logic        int_req_i = 1'b0;
  logic [31:0] int_addr_i = '0;
  logic        int_ack_o;
  logic        bus_hold_req_i = 1'b0;
  logic        bus_grant_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [2:0]  hold_flag_o;
  logic        timeout_o;

  typedef struct {
    string       nm;
    logic        jf;
    logic [31:0] ja;
    logic [2:0]  hf;
    logic        ack;
    logic        gnt;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;

  pipe_ctrl #(
    .DRAIN_CYCLES (3),
    .STALL_TIMEOUT(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_jump_req_i (ex_jump_req_i),
    .ex_jump_addr_i(ex_jump_addr_i),
    .ex_hold_req_i (ex_hold_req_i),
    .int_req_i     (int_req_i),
    .int_addr_i    (int_addr_i),
    .int_ack_o     (int_ack_o),
    .bus_hold_req_i(bus_hold_req_i),
    .bus_grant_o   (bus_grant_o),
    .jump_flag_o   (jump_flag_o),
    .jump_addr_o   (jump_addr_o),
    .hold_flag_o   (hold_flag_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per cycle
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (jump_flag_o === e.jf && jump_addr_o === e.ja &&
          hold_flag_o === e.hf && int_ack_o === e.ack &&
          bus_grant_o === e.gnt && timeout_o === e.to) begin
        passed++;
      end else begin
        $display("FAIL %s: got jf=%0b ja=%h hf=%0d ack=%0b gnt=%0b to=%0b want jf=%0b ja=%h hf=%0d ack=%0b gnt=%0b to=%0b",
                 e.nm, jump_flag_o, jump_addr_o, hold_flag_o,
                 int_ack_o, bus_grant_o, timeout_o,
                 e.jf, e.ja, e.hf, e.ack, e.gnt, e.to);
      end
    end
  end

  task automatic step(
    input string       nm,
    input logic        r,
    input logic        ej,
    input logic [31:0] ea,
    input logic        eh,
    input logic        ir,
    input logic [31:0] ia,
    input logic        bh,
    input logic        xjf,
    input logic [31:0] xja,
    input logic [2:0]  xhf,
    input logic        xack,
    input logic        xgnt,
    input logic        xto
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst            = r;
    ex_jump_req_i  = ej;
    ex_jump_addr_i = ea;
    ex_hold_req_i  = eh;
    int_req_i      = ir;
    int_addr_i     = ia;
    bus_hold_req_i = bh;
    e.nm  = nm;
    e.jf  = xjf;
    e.ja  = xja;
    e.hf  = xhf;
    e.ack = xack;
    e.gnt = xgnt;
    e.to  = xto;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL guard: simulation time limit");
    $fatal(1, "time limit");
  end

  initial begin
    step("rst",  1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    step("idle", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    step("exj",    0, 1, 'h100, 0, 0, 0, 0,  1, 'h100, 3, 0, 0, 0);
    step("exj_nx", 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0);

    step("col0", 0, 1, 'h200, 0, 1, 'h80, 0,  1, 'h200, 3, 0, 0, 0);
    step("col1", 0, 0, 0, 0, 1, 'h80, 0,      1, 'h80, 3, 1, 0, 0);
    step("held", 0, 0, 0, 0, 1, 'h80, 0,      0, 0, 0, 0, 0, 0);
    step("held", 0, 0, 0, 0, 1, 'h80, 0,      0, 0, 0, 0, 0, 0);
    step("idrop", 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0);
    step("reint", 0, 0, 0, 0, 1, 'h84, 0,     1, 'h84, 3, 1, 0, 0);
    step("rdrop", 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0);

    step("bus_c0", 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("drain", 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0);
    step("grant",   0, 0, 0, 0, 0, 0, 1,      0, 0, 3, 0, 1, 0);
    step("gnt_ej",  0, 1, 'h300, 0, 0, 0, 1,  0, 0, 3, 0, 1, 0);
    step("gnt_int", 0, 0, 0, 0, 1, 'h90, 1,   0, 0, 3, 0, 1, 0);
    step("gnt_rel", 0, 0, 0, 0, 0, 0, 0,      0, 0, 3, 0, 1, 0);
    step("gnt_off", 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0);

    step("ab_c0", 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    step("ab_c1", 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0);
    step("ab_c2", 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
    step("ab_c3", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    step("ab_c4", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    step("dj_c0",  0, 0, 0, 0, 0, 0, 1,      0, 0, 0, 0, 0, 0);
    step("dj_c1",  0, 0, 0, 0, 0, 0, 1,      0, 0, 1, 0, 0, 0);
    step("dj_c2",  0, 1, 'h400, 0, 0, 0, 1,  1, 'h400, 3, 0, 0, 0);
    step("dj_c3",  0, 0, 0, 0, 0, 0, 1,      0, 0, 1, 0, 0, 0);
    step("dj_c4",  0, 0, 0, 0, 0, 0, 1,      0, 0, 3, 0, 1, 0);
    step("dj_rel", 0, 0, 0, 0, 0, 0, 0,      0, 0, 3, 0, 1, 0);
    step("dj_off", 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0);

    step("rg_c0", 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("rg_drain", 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0);
    step("rg_gnt",  0, 0, 0, 0, 0, 0, 1,  0, 0, 3, 0, 1, 0);
    step("rg_rst",  1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    step("rg_post", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 5; i++)
      step("blk", 0, 0, 0, 1, 0, 0, 1,  0, 0, 3, 0, 0, 0);
    step("blk_rel",   0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    step("blk_drain", 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 0);
    step("blk_ab",    0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
    step("blk_idle",  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 7; i++)
      step("wd7a", 0, 0, 0, 1, 0, 0, 0,  0, 0, 3, 0, 0, 0);
    step("wd_gap", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      step("wd7b", 0, 0, 0, 1, 0, 0, 0,  0, 0, 3, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      step("wd7_end", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      step("wd8", 0, 0, 0, 1, 0, 0, 0,  0, 0, 3, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      step("wd_to", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    step("wd_sticky", 0, 1, 'h500, 0, 0, 0, 0,  1, 'h500, 3, 0, 0, 1);
    step("wd_rst",    1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0);
    step("wd_clr",    0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0);

    @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
